nes_controller_emulator: RTL

Console-facing emulation of a standard NES controller: the FPGA presents button states on the controller port's serial data line in response to the console's latch and clock strobes. It sits at the board-edge controller port, opposite the console's reader, and is fed by on-board buttons or a host-side button register. All console inputs are asynchronous and are synchronized to the system clock internally.

---
 rtl/nes_controller_emulator_pkg.sv | 23 ++
 rtl/nes_controller_emulator_if.sv | 30 +++
 rtl/nes_controller_emulator_sync_edge.sv | 37 +++
 rtl/nes_controller_emulator.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/nes_controller_emulator_pkg.sv
// Shared types and constants for the NES controller emulator.
// The optional turbo feature is compiled in with the NES_TURBO_EN macro.
package nes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } nes_state_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NES_BITS = 8;

endpackage

// File: rtl/nes_controller_emulator_if.sv
// Controller-port bundle: console strobes in, serial data and frame status out.
// The master modport is the console side, the slave modport is the emulator.
interface nes_controller_emulator_if;

    logic       latch_in;
    logic       pulse_in;
    logic       data_out;
    logic [3:0] bits_sent;
    logic       frame_strobe;
    logic       console_idle;

    modport master (
        output latch_in,
        output pulse_in,
        input  data_out,
        input  bits_sent,
        input  frame_strobe,
        input  console_idle
    );

    modport slave (
        input  latch_in,
        input  pulse_in,
        output data_out,
        output bits_sent,
        output frame_strobe,
        output console_idle
    );

endinterface

// File: rtl/nes_controller_emulator_sync_edge.sv
// Multi-stage synchronizer for an asynchronous console strobe, with
// registered one-cycle rise and fall pulses taken from the synchronized level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/nes_controller_emulator.sv
// NES controller emulation: serializes button states to the console on its
// latch/pulse strobes. Define NES_TURBO_EN to build the per-button turbo gate.
module nes_controller_emulator
    import nes_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TURBO_PERIOD   = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_buttons,
    input  logic [7:0] i_turbo_mask,
    nes_controller_emulator_if.slave port
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    nes_state_t        r_state;
    nes_state_t        w_next;
    logic [7:0]        r_shreg;
    logic [3:0]        r_bits;
    logic [WD_W-1:0]   r_wdog;
    logic [7:0]        w_eff_buttons;
    logic              w_data_out;
    logic              w_frame_strobe;

    logic w_latch_level;
    logic w_latch_rise;
    logic w_latch_fall;
    logic w_pulse_rise;
    logic w_unused_pulse_level;
    logic w_unused_pulse_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_latch (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (port.latch_in),
        .o_level (w_latch_level),
        .o_rise  (w_latch_rise),
        .o_fall  (w_latch_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pulse (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (port.pulse_in),
        .o_level (w_unused_pulse_level),
        .o_rise  (w_pulse_rise),
        .o_fall  (w_unused_pulse_fall)
    );

`ifdef NES_TURBO_EN
    localparam int TP_W = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

    logic [TP_W-1:0] r_turbo_cnt;
    logic            r_turbo_phase;

    // Phase flips once every TURBO_PERIOD completed latches.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= 1'b0;
        end else if (w_frame_strobe) begin
            if (r_turbo_cnt == TP_W'(TURBO_PERIOD - 1)) begin
                r_turbo_cnt   <= '0;
                r_turbo_phase <= ~r_turbo_phase;
            end else begin
                r_turbo_cnt <= r_turbo_cnt + TP_W'(1);
            end
        end
    end

    assign w_eff_buttons = i_buttons & ~(i_turbo_mask & {8{r_turbo_phase}});
`else
    logic w_unused_turbo;

    assign w_unused_turbo = (^i_turbo_mask) ^ (TURBO_PERIOD > 0);
    assign w_eff_buttons  = i_buttons;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A latch rising edge wins over everything, including a same-cycle pulse.
    always_comb begin
        w_next = r_state;
        if (w_latch_rise) begin
            w_next = LOAD;
        end else begin
            case (r_state)
                IDLE:    w_next = IDLE;
                LOAD:    if (w_latch_fall) w_next = SHIFT;
                SHIFT:   if (w_pulse_rise && (r_bits == 4'(NES_BITS - 1))) w_next = DONE;
                DONE:    w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_data_out     = 1'b1;
        w_frame_strobe = 1'b0;
        case (r_state)
            LOAD: begin
                w_data_out     = ~r_shreg[BTN_A];
                w_frame_strobe = w_latch_fall & ~w_latch_rise;
            end
            SHIFT:   w_data_out = ~r_shreg[BTN_A];
            default: w_data_out = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shreg <= '0;
            r_bits  <= '0;
        end else if (w_latch_rise) begin
            r_shreg <= w_eff_buttons;
            r_bits  <= '0;
        end else if (r_state == LOAD) begin
            if (w_latch_level) begin
                r_shreg <= w_eff_buttons;
            end
            r_bits <= '0;
        end else if ((r_state == SHIFT) && w_pulse_rise) begin
            r_shreg <= {1'b0, r_shreg[7:1]};
            r_bits  <= r_bits + 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wdog <= '0;
        end else if (w_latch_rise) begin
            r_wdog <= '0;
        end else if (r_wdog != WD_W'(TIMEOUT_CYCLES)) begin
            r_wdog <= r_wdog + WD_W'(1);
        end
    end

    assign port.data_out     = w_data_out;
    assign port.bits_sent    = r_bits;
    assign port.frame_strobe = w_frame_strobe;
    assign port.console_idle = (r_wdog == WD_W'(TIMEOUT_CYCLES));

endmodule
